// File: rtl/rv32i_types.sv
// Shared fetch-stage types: fetch FSM states, the IF/ID packet layout and the boot PC.
package rv32i_types;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0060;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pred_target;
        logic        pred_taken;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: walks the BTB-predicted PC stream, issues icache reads and
// hands one packet at a time to IF/ID, with a one-entry buffer and redirect squash.
module fetch_pc_gen
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    output logic [31:0]  br_pc,
    input  logic [31:0]  predict_target,
    input  logic         isMiss,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    input  logic         stall,
    output logic         imem_read,
    output logic [31:0]  imem_address,
    input  logic         imem_resp,
    input  logic [31:0]  imem_rdata,
    output logic         if_valid,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_instr,
    output logic [31:0]  if_pred_target,
    output logic         if_pred_taken,
    output fetch_state_e state_dbg
);

    // Handshake: a packet moves to IF/ID on every cycle where if_valid=1 and stall=0.
    fetch_state_e state_q, state_n;
    logic [31:0]  pc_q, pc_n;
    logic [31:0]  kill_addr_q, kill_addr_n;
    logic         valid_q, valid_n;
    fetch_pkt_t   pkt_q, pkt_n;
    logic         buf_valid_q, buf_valid_n;
    fetch_pkt_t   buf_q, buf_n;
    fetch_pkt_t   resp_pkt;
    logic         transfer;

    assign transfer = valid_q && !stall;
    assign resp_pkt = '{pc: pc_q, instr: imem_rdata, pred_target: predict_target,
                        pred_taken: ~isMiss};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            kill_addr_q <= '0;
            valid_q     <= 1'b0;
            pkt_q       <= '0;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_n;
            pc_q        <= pc_n;
            kill_addr_q <= kill_addr_n;
            valid_q     <= valid_n;
            pkt_q       <= pkt_n;
            buf_valid_q <= buf_valid_n;
            buf_q       <= buf_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        pc_n        = pc_q;
        kill_addr_n = kill_addr_q;
        valid_n     = valid_q;
        pkt_n       = pkt_q;
        buf_valid_n = buf_valid_q;
        buf_n       = buf_q;

        if (redirect) begin
            pc_n        = redirect_pc;
            valid_n     = 1'b0;
            buf_valid_n = 1'b0;
            unique case (state_q)
                FETCH: begin
                    // No response yet: the icache still owes us data for the old address.
                    if (!imem_resp) begin
                        kill_addr_n = pc_q;
                        state_n     = KILL;
                    end
                end
                HOLD:    state_n = FETCH;
                KILL:    if (imem_resp) state_n = FETCH;
                default: state_n = FETCH;
            endcase
        end else begin
            if (transfer) valid_n = 1'b0;
            unique case (state_q)
                FETCH: begin
                    if (imem_resp) begin
                        pc_n = predict_target;
                        if (!valid_q || transfer) begin
                            pkt_n   = resp_pkt;
                            valid_n = 1'b1;
                        end else begin
                            buf_n       = resp_pkt;
                            buf_valid_n = 1'b1;
                            state_n     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (transfer) begin
                        pkt_n       = buf_q;
                        valid_n     = 1'b1;
                        buf_valid_n = 1'b0;
                        state_n     = FETCH;
                    end
                end
                KILL:    if (imem_resp) state_n = FETCH;
                default: state_n = FETCH;
            endcase
        end
    end

    // Reset gates the read so an in-flight request is abandoned immediately.
    assign imem_read      = !rst && (state_q != HOLD);
    assign imem_address   = (state_q == KILL) ? kill_addr_q : pc_q;
    assign br_pc          = pc_q;
    assign if_valid       = valid_q;
    assign if_pc          = pkt_q.pc;
    assign if_instr       = pkt_q.instr;
    assign if_pred_target = pkt_q.pred_target;
    assign if_pred_taken  = pkt_q.pred_taken;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: driver tasks model icache/BTB, a monitor
// checks every delivered packet against an expected queue.
module tb_fetch_pc_gen;
    import rv32i_types::*;

    localparam int PW = 97;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  br_pc;
    logic [31:0]  predict_target = '0;
    logic         isMiss = 1'b0;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic         stall = 1'b0;
    logic         imem_read;
    logic [31:0]  imem_address;
    logic         imem_resp = 1'b0;
    logic [31:0]  imem_rdata = '0;
    logic         if_valid;
    logic [31:0]  if_pc, if_instr, if_pred_target;
    logic         if_pred_taken;
    fetch_state_e state_dbg;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q[$];

    fetch_pc_gen #(.RESET_PC(32'h4000_0060)) dut (
        .clk(clk), .rst(rst), .br_pc(br_pc), .predict_target(predict_target),
        .isMiss(isMiss), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .imem_read(imem_read), .imem_address(imem_address),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_instr(if_instr), .if_pred_target(if_pred_target),
        .if_pred_taken(if_pred_taken), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One-cycle icache response together with the BTB answer for br_pc.
    task automatic icache_resp(input logic [31:0] data, input logic [31:0] tgt,
                               input logic miss, input logic redir,
                               input logic [31:0] rpc);
        imem_resp      = 1'b1;
        imem_rdata     = data;
        predict_target = tgt;
        isMiss         = miss;
        redirect       = redir;
        redirect_pc    = rpc;
        next_cycle();
        imem_resp      = 1'b0;
        redirect       = 1'b0;
        predict_target = '0;
        isMiss         = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] rpc);
        redirect    = 1'b1;
        redirect_pc = rpc;
        next_cycle();
        redirect    = 1'b0;
    endtask

    task automatic push_pkt(input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] tgt, input logic taken);
        exp_q.push_back({pc, instr, tgt, taken});
    endtask

    // Monitor: a packet is consumed on each cycle with if_valid=1 and stall=0.
    always @(negedge clk) begin
        if (if_valid && !stall) begin
            logic [PW-1:0] exp_pkt;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pkt: got pc %h instr %h expected no packet", if_pc, if_instr);
            end else begin
                exp_pkt = exp_q.pop_front();
                if ({if_pc, if_instr, if_pred_target, if_pred_taken} !== exp_pkt) begin
                    errors++;
                    $display("FAIL pkt: got %h %h %h %b expected %h %h %h %b",
                             if_pc, if_instr, if_pred_target, if_pred_taken,
                             exp_pkt[96:65], exp_pkt[64:33], exp_pkt[32:1], exp_pkt[0]);
                end
            end
        end
    end

    initial begin
        // Reset values
        repeat (2) next_cycle();
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_imem_read", 32'(imem_read), 32'd0);
        check("rst_br_pc", br_pc, 32'h4000_0060);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_state", 32'(state_dbg), 32'(FETCH));
        rst = 1'b0;
        next_cycle();
        check("boot_read", 32'(imem_read), 32'd1);
        check("boot_addr", imem_address, 32'h4000_0060);

        // First fetch: two-cycle icache latency, BTB miss
        next_cycle();
        check("boot_addr_held", imem_address, 32'h4000_0060);
        push_pkt(32'h4000_0060, 32'h0000_0013, 32'h4000_0064, 1'b0);
        icache_resp(32'h0000_0013, 32'h4000_0064, 1'b1, 1'b0, '0);
        check("seq_addr", imem_address, 32'h4000_0064);
        check("seq_valid", 32'(if_valid), 32'd1);

        // BTB hit steers the next read
        push_pkt(32'h4000_0064, 32'h1111_1111, 32'h4000_0100, 1'b1);
        icache_resp(32'h1111_1111, 32'h4000_0100, 1'b0, 1'b0, '0);
        check("hit_addr", imem_address, 32'h4000_0100);
        check("hit_br_pc", br_pc, 32'h4000_0100);
        next_cycle();

        // Stall across two responses: second lands in the buffer
        stall = 1'b1;
        push_pkt(32'h4000_0100, 32'haaaa_0001, 32'h4000_0104, 1'b0);
        icache_resp(32'haaaa_0001, 32'h4000_0104, 1'b1, 1'b0, '0);
        check("stall_addr", imem_address, 32'h4000_0104);
        push_pkt(32'h4000_0104, 32'haaaa_0002, 32'h4000_0108, 1'b0);
        icache_resp(32'haaaa_0002, 32'h4000_0108, 1'b1, 1'b0, '0);
        check("hold_state", 32'(state_dbg), 32'(HOLD));
        check("hold_read", 32'(imem_read), 32'd0);
        check("hold_br_pc", br_pc, 32'h4000_0108);
        next_cycle();
        check("hold_state2", 32'(state_dbg), 32'(HOLD));
        stall = 1'b0;
        next_cycle();
        check("unhold_state", 32'(state_dbg), 32'(FETCH));
        check("unhold_read", 32'(imem_read), 32'd1);
        check("unhold_addr", imem_address, 32'h4000_0108);
        next_cycle();
        check("drain_valid", 32'(if_valid), 32'd0);

        // Redirect with a request outstanding -> KILL
        do_redirect(32'h4000_0200);
        check("kill_state", 32'(state_dbg), 32'(KILL));
        check("kill_addr", imem_address, 32'h4000_0108);
        check("kill_read", 32'(imem_read), 32'd1);
        check("kill_br_pc", br_pc, 32'h4000_0200);
        next_cycle();
        check("kill_addr_held", imem_address, 32'h4000_0108);
        icache_resp(32'hdead_beef, 32'h1234_5678, 1'b0, 1'b0, '0);
        check("postkill_state", 32'(state_dbg), 32'(FETCH));
        check("postkill_addr", imem_address, 32'h4000_0200);
        check("postkill_valid", 32'(if_valid), 32'd0);

        // Redirect coinciding with a response: data dropped
        icache_resp(32'hbad0_0001, 32'h4000_0204, 1'b1, 1'b1, 32'h4000_0300);
        check("samecyc_state", 32'(state_dbg), 32'(FETCH));
        check("samecyc_addr", imem_address, 32'h4000_0300);
        check("samecyc_valid", 32'(if_valid), 32'd0);

        // Second redirect while killing only moves pc, then reset mid-KILL
        do_redirect(32'h4000_0400);
        do_redirect(32'h4000_0500);
        check("rekill_state", 32'(state_dbg), 32'(KILL));
        check("rekill_addr", imem_address, 32'h4000_0300);
        check("rekill_br_pc", br_pc, 32'h4000_0500);
        rst = 1'b1;
        #1;
        check("midrst_read", 32'(imem_read), 32'd0);
        check("midrst_br_pc", br_pc, 32'h4000_0060);
        check("midrst_state", 32'(state_dbg), 32'(FETCH));
        check("midrst_valid", 32'(if_valid), 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        check("restart_read", 32'(imem_read), 32'd1);
        check("restart_addr", imem_address, 32'h4000_0060);
        push_pkt(32'h4000_0060, 32'h0000_0093, 32'h4000_0064, 1'b0);
        icache_resp(32'h0000_0093, 32'h4000_0064, 1'b1, 1'b0, '0);
        check("restart_next", imem_address, 32'h4000_0064);

        repeat (3) next_cycle();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h4000_0060, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port br_pc  output  32  current fetch PC, driven to the BTB lookup.
REQ-005 SHALL have port predict_target  input  32  BTB predicted next PC for br_pc (br_pc+4 on miss).
REQ-006 SHALL have port isMiss  input  1  BTB miss flag for br_pc.
REQ-007 SHALL have port redirect  input  1  EX/MEM mispredict; fetch must restart at redirect_pc.
REQ-008 SHALL have port redirect_pc  input  32  corrected PC.
REQ-009 SHALL have port stall  input  1  IF/ID cannot accept a packet this cycle.
REQ-010 SHALL have port imem_read  output  1  instruction-cache read request.
REQ-011 SHALL have port imem_address  output  32  request address; held stable while imem_read=1 until imem_resp.
REQ-012 SHALL have ports imem_resp (input, 1) and imem_rdata (input, 32): response strobe and data.
REQ-013 SHALL have output packet ports if_valid (1), if_pc (32), if_instr (32), if_pred_target (32), if_pred_taken (1).

Function
REQ-014 SHALL implement states FETCH (request outstanding), HOLD (response captured, packet slot full) and KILL (stale request outstanding after redirect).
REQ-015 SHALL drive br_pc = pc register at all times and sample predict_target/isMiss only in the cycle imem_resp=1.
REQ-016 SHALL transfer a packet on any cycle with if_valid=1 and stall=0; if_valid clears after transfer unless reloaded the same cycle.
REQ-017 In FETCH SHALL assert imem_read=1 with imem_address=pc.
REQ-018 In FETCH, on imem_resp with redirect=0, SHALL set pc<=predict_target; packet <= {pc, imem_rdata, predict_target, ~isMiss} if the slot is free or transferring, staying in FETCH; otherwise SHALL store it in a one-entry buffer and enter HOLD.
REQ-019 In HOLD SHALL deassert imem_read; on transfer SHALL move the buffer into the packet and return to FETCH.
REQ-020 Redirect SHALL take priority over all other events in every state: pc<=redirect_pc, if_valid<=0, buffer dropped.
REQ-021 A redirect in FETCH without a same-cycle imem_resp SHALL latch the outstanding address into kill_addr and enter KILL.
REQ-022 A redirect in FETCH with a same-cycle imem_resp, or in HOLD, SHALL discard the data and enter FETCH.
REQ-023 In KILL SHALL keep imem_read=1 with imem_address=kill_addr; on imem_resp SHALL discard the data and enter FETCH; a further redirect in KILL SHALL only update pc.
REQ-024 pc arithmetic SHALL be 32-bit with wrap-around; no alignment checking.

Reset
REQ-025 While rst=1 SHALL hold pc=RESET_PC, state=FETCH, if_valid=0, buffer empty, imem_read=0, and all packet fields 0.
REQ-026 Reset asserted mid-request SHALL abandon the request; the first cycle after release SHALL issue a read at RESET_PC.

Structure
REQ-027 SHALL take the state enum type and the RESET_PC default value from rv32i_types.
REQ-028 SHALL be a single module with no sub-modules; the BTB is instantiated alongside it and connected through br_pc, predict_target and isMiss.

Verification
REQ-029 Reset release, icache responds after 2 cycles, BTB miss -> packet {pc=0x40000060, pred_taken=0, pred_target=0x40000064}, next read at 0x40000064.
REQ-030 BTB hit on 0x40000064 with target 0x40000100 -> next imem_address=0x40000100, if_pred_taken=1.
REQ-031 stall=1 across two responses -> second response goes to HOLD with imem_read=0; stall=0 -> packets delivered in order, no loss or duplication.
REQ-032 redirect to 0x40000200 while a request is outstanding -> KILL with imem_address held; the stale response is dropped and the next read is at 0x40000200.
REQ-033 redirect in the same cycle as imem_resp -> no packet produced, next read at redirect_pc.
REQ-034 rst pulsed mid-KILL -> all outputs return to reset values immediately, and fetch restarts at RESET_PC.
